// File: rtl/avalon_cipher_csr.sv
// avalon_cipher_csr
// Avalon-MM CSR slave that fronts a block-cipher core. Software loads the key
// and message words, pulses START through CTRL, and the block launches the
// core with a one-cycle CORE_START. On CORE_DONE it captures the result and
// sets a sticky DONE flag. A watchdog aborts the operation if the core never
// answers. KEY/MSG writes are refused while an operation is in flight and
// set a sticky LOCK_ERR flag.
//
// Register map (word addresses):
//   0 .. KEY_WORDS-1                 KEY   (R/W, byte-enable merged)
//   KEY_WORDS .. +MSG_WORDS-1        MSG   (R/W, byte-enable merged)
//   KEY_WORDS+MSG_WORDS .. +MSG-1    RES   (RO)
//   2**ADDR_W-2                      CTRL  bit0 START (pulse), bit1 IE (with IRQ)
//   2**ADDR_W-1                      STATUS bit0 BUSY, bit1 DONE, bit2 LOCK_ERR,
//                                    bit3 TIMEOUT (bits 1-3 sticky, W1C)
//
// Ports:
//   CLK, RESET                 clock, asynchronous active-high reset
//   AVL_CS/READ/WRITE          Avalon-MM strobes, honoured only with AVL_CS
//   AVL_BYTE_EN, AVL_ADDR      write byte enables, word address
//   AVL_WRITEDATA              write data
//   AVL_READDATA               registered read data (latency 1, 0 when idle)
//   CORE_START                 one-cycle launch pulse to the core
//   CORE_KEY, CORE_MSG         key/message words, word 0 in the top 32 bits
//   CORE_DONE, CORE_RESULT     completion pulse and result from the core
//   EXPORT_DATA                {key word 0 [31:16], last key word [15:0]}
//   AVL_IRQ                    interrupt, only when CIPHER_CSR_IRQ_EN is defined
//
// Configuration macro: CIPHER_CSR_IRQ_EN adds AVL_IRQ and the CTRL IE bit.

module avalon_cipher_csr #(
    parameter int KEY_WORDS   = 4,
    parameter int MSG_WORDS   = 4,
    parameter int ADDR_W      = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   AVL_READ,
    input  logic                   AVL_WRITE,
    input  logic                   AVL_CS,
    input  logic [3:0]             AVL_BYTE_EN,
    input  logic [ADDR_W-1:0]      AVL_ADDR,
    input  logic [31:0]            AVL_WRITEDATA,
    output logic [31:0]            AVL_READDATA,
    output logic                   CORE_START,
    output logic [32*KEY_WORDS-1:0] CORE_KEY,
    output logic [32*MSG_WORDS-1:0] CORE_MSG,
    input  logic                   CORE_DONE,
    input  logic [32*MSG_WORDS-1:0] CORE_RESULT,
`ifdef CIPHER_CSR_IRQ_EN
    output logic                   AVL_IRQ,
`endif
    output logic [31:0]            EXPORT_DATA
);

    localparam logic [31:0] MSG_BASE    = 32'(KEY_WORDS);
    localparam logic [31:0] RES_BASE    = 32'(KEY_WORDS + MSG_WORDS);
    localparam logic [31:0] CTRL_ADDR   = 32'((1 << ADDR_W) - 2);
    localparam logic [31:0] STATUS_ADDR = 32'((1 << ADDR_W) - 1);
    // Terminal watchdog count; unreachable all-ones when the watchdog is off.
    localparam logic [31:0] TO_LAST     = (TIMEOUT_CYC > 0) ? 32'(TIMEOUT_CYC - 1)
                                                            : 32'hFFFF_FFFF;

    typedef enum logic [1:0] {IDLE, LAUNCH, BUSY} state_t;

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] key_q [KEY_WORDS];
    logic [31:0] key_d [KEY_WORDS];
    logic [31:0] msg_q [MSG_WORDS];
    logic [31:0] msg_d [MSG_WORDS];
    logic [31:0] res_q [MSG_WORDS];
    logic [31:0] res_d [MSG_WORDS];
    logic        done_q, done_d;
    logic        lock_err_q, lock_err_d;
    logic        timeout_q, timeout_d;
    logic        core_start_q, core_start_d;
    logic [31:0] rdata_q, rdata_d;
`ifdef CIPHER_CSR_IRQ_EN
    logic        ie_q, ie_d;
`endif

    logic [31:0] addr;
    logic        wr_en, rd_en, start_req;
    logic        set_done, set_lock, set_timeout;
    logic [31:0] ctrl_rd, status_rd;

    assign addr  = {{(32-ADDR_W){1'b0}}, AVL_ADDR};
    assign wr_en = AVL_CS & AVL_WRITE;
    assign rd_en = AVL_CS & AVL_READ;
    assign start_req = wr_en && (addr == CTRL_ADDR) && AVL_BYTE_EN[0] && AVL_WRITEDATA[0];

`ifdef CIPHER_CSR_IRQ_EN
    assign ctrl_rd = {30'd0, ie_q, 1'b0};
    assign AVL_IRQ = ie_q & (done_q | timeout_q | lock_err_q);
`else
    assign ctrl_rd = 32'd0;
`endif
    assign status_rd = {28'd0, timeout_q, lock_err_q, done_q, state_q != IDLE};

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  be);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) begin
            r[8*b +: 8] = be[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
        end
        return r;
    endfunction

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        key_d        = key_q;
        msg_d        = msg_q;
        res_d        = res_q;
        done_d       = done_q;
        lock_err_d   = lock_err_q;
        timeout_d    = timeout_q;
        rdata_d      = 32'd0;
        set_done     = 1'b0;
        set_lock     = 1'b0;
        set_timeout  = 1'b0;
`ifdef CIPHER_CSR_IRQ_EN
        ie_d         = ie_q;
`endif

        // W1C is applied first so that set events below override it.
        if (wr_en && addr == STATUS_ADDR && AVL_BYTE_EN[0]) begin
            if (AVL_WRITEDATA[1]) done_d     = 1'b0;
            if (AVL_WRITEDATA[2]) lock_err_d = 1'b0;
            if (AVL_WRITEDATA[3]) timeout_d  = 1'b0;
        end

        // Key/message updates are only accepted while no operation is in flight.
        for (int i = 0; i < KEY_WORDS; i++) begin
            if (wr_en && addr == 32'(i)) begin
                if (state_q == IDLE) key_d[i] = merge_bytes(key_q[i], AVL_WRITEDATA, AVL_BYTE_EN);
                else                 set_lock = 1'b1;
            end
        end
        for (int i = 0; i < MSG_WORDS; i++) begin
            if (wr_en && addr == MSG_BASE + 32'(i)) begin
                if (state_q == IDLE) msg_d[i] = merge_bytes(msg_q[i], AVL_WRITEDATA, AVL_BYTE_EN);
                else                 set_lock = 1'b1;
            end
        end

`ifdef CIPHER_CSR_IRQ_EN
        if (wr_en && addr == CTRL_ADDR && AVL_BYTE_EN[0]) ie_d = AVL_WRITEDATA[1];
`endif

        case (state_q)
            IDLE: begin
                if (start_req) state_d = LAUNCH;
            end
            LAUNCH: begin
                state_d   = BUSY;
                cnt_d     = 32'd0;
                done_d    = 1'b0;
                timeout_d = 1'b0;
            end
            BUSY: begin
                // A completion in the terminal-count cycle takes priority over the abort.
                if (CORE_DONE) begin
                    for (int i = 0; i < MSG_WORDS; i++) begin
                        res_d[i] = CORE_RESULT[32*(MSG_WORDS-i)-1 -: 32];
                    end
                    set_done = 1'b1;
                    state_d  = IDLE;
                end else if (TIMEOUT_CYC != 0 && cnt_q == TO_LAST) begin
                    set_timeout = 1'b1;
                    state_d     = IDLE;
                end else if (cnt_q != 32'hFFFF_FFFF) begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (set_done)    done_d     = 1'b1;
        if (set_lock)    lock_err_d = 1'b1;
        if (set_timeout) timeout_d  = 1'b1;

        core_start_d = (state_d == LAUNCH);

        if (rd_en) begin
            for (int i = 0; i < KEY_WORDS; i++) begin
                if (addr == 32'(i)) rdata_d = key_q[i];
            end
            for (int i = 0; i < MSG_WORDS; i++) begin
                if (addr == MSG_BASE + 32'(i)) rdata_d = msg_q[i];
                if (addr == RES_BASE + 32'(i)) rdata_d = res_q[i];
            end
            if (addr == CTRL_ADDR)   rdata_d = ctrl_rd;
            if (addr == STATUS_ADDR) rdata_d = status_rd;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q      <= IDLE;
            cnt_q        <= 32'd0;
            for (int i = 0; i < KEY_WORDS; i++) key_q[i] <= 32'd0;
            for (int i = 0; i < MSG_WORDS; i++) begin
                msg_q[i] <= 32'd0;
                res_q[i] <= 32'd0;
            end
            done_q       <= 1'b0;
            lock_err_q   <= 1'b0;
            timeout_q    <= 1'b0;
            core_start_q <= 1'b0;
            rdata_q      <= 32'd0;
`ifdef CIPHER_CSR_IRQ_EN
            ie_q         <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            key_q        <= key_d;
            msg_q        <= msg_d;
            res_q        <= res_d;
            done_q       <= done_d;
            lock_err_q   <= lock_err_d;
            timeout_q    <= timeout_d;
            core_start_q <= core_start_d;
            rdata_q      <= rdata_d;
`ifdef CIPHER_CSR_IRQ_EN
            ie_q         <= ie_d;
`endif
        end
    end

    for (genvar g = 0; g < KEY_WORDS; g++) begin : g_key
        assign CORE_KEY[32*(KEY_WORDS-g)-1 -: 32] = key_q[g];
    end
    for (genvar g = 0; g < MSG_WORDS; g++) begin : g_msg
        assign CORE_MSG[32*(MSG_WORDS-g)-1 -: 32] = msg_q[g];
    end

    assign AVL_READDATA = rdata_q;
    assign CORE_START   = core_start_q;
    assign EXPORT_DATA  = {key_q[0][31:16], key_q[KEY_WORDS-1][15:0]};

endmodule

// File: tb/tb_avalon_cipher_csr.sv
// tb_avalon_cipher_csr
// Self-checking bench for avalon_cipher_csr with a 16-cycle watchdog.
// A register-level model (arrays plus sticky flags) predicts every readback.
// Build with CIPHER_CSR_IRQ_EN defined to also exercise the interrupt.

module tb_avalon_cipher_csr;

    localparam int KW = 4;
    localparam int MW = 4;
    localparam int AW = 4;
    localparam int TO = 16;
    localparam int CTRL_A   = 14;
    localparam int STATUS_A = 15;

    logic           CLK = 1'b0;
    logic           RESET = 1'b1;
    logic           AVL_READ = 1'b0;
    logic           AVL_WRITE = 1'b0;
    logic           AVL_CS = 1'b0;
    logic [3:0]     AVL_BYTE_EN = 4'h0;
    logic [AW-1:0]  AVL_ADDR = '0;
    logic [31:0]    AVL_WRITEDATA = 32'd0;
    logic [31:0]    AVL_READDATA;
    logic           CORE_START;
    logic [127:0]   CORE_KEY;
    logic [127:0]   CORE_MSG;
    logic           CORE_DONE = 1'b0;
    logic [127:0]   CORE_RESULT = '0;
    logic [31:0]    EXPORT_DATA;
`ifdef CIPHER_CSR_IRQ_EN
    logic           AVL_IRQ;
`endif

    avalon_cipher_csr #(
        .KEY_WORDS(KW), .MSG_WORDS(MW), .ADDR_W(AW), .TIMEOUT_CYC(TO)
    ) dut (
        .CLK(CLK), .RESET(RESET), .AVL_READ(AVL_READ), .AVL_WRITE(AVL_WRITE),
        .AVL_CS(AVL_CS), .AVL_BYTE_EN(AVL_BYTE_EN), .AVL_ADDR(AVL_ADDR),
        .AVL_WRITEDATA(AVL_WRITEDATA), .AVL_READDATA(AVL_READDATA),
        .CORE_START(CORE_START), .CORE_KEY(CORE_KEY), .CORE_MSG(CORE_MSG),
        .CORE_DONE(CORE_DONE), .CORE_RESULT(CORE_RESULT),
`ifdef CIPHER_CSR_IRQ_EN
        .AVL_IRQ(AVL_IRQ),
`endif
        .EXPORT_DATA(EXPORT_DATA)
    );

    always #5 CLK = ~CLK;

    int testsRun    = 0;
    int testsFailed = 0;
    int startCount  = 0;

    // Launch pulses are counted on the falling edge, away from register updates.
    always @(negedge CLK) if (CORE_START) startCount++;

    logic [31:0] keyMdl [KW];
    logic [31:0] msgMdl [MW];
    logic [31:0] resMdl [MW];
    bit          doneMdl, lockMdl, toMdl, ieMdl, busyMdl;

    task automatic checkOutput(input string tag, input logic [127:0] actual,
                               input logic [127:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < KW; i++) keyMdl[i] = 32'd0;
        for (int i = 0; i < MW; i++) begin
            msgMdl[i] = 32'd0;
            resMdl[i] = 32'd0;
        end
        doneMdl = 0; lockMdl = 0; toMdl = 0; ieMdl = 0; busyMdl = 0;
    endtask

    function automatic logic [31:0] byteMerge(input logic [31:0] oldW, input logic [31:0] newW,
                                              input logic [3:0] be);
        logic [31:0] mask;
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (oldW & ~mask) | (newW & mask);
    endfunction

    function automatic logic [127:0] packWords(input logic [31:0] w [4]);
        logic [127:0] v = '0;
        for (int i = 0; i < 4; i++) v = (v << 32) | 128'(w[i]);
        return v;
    endfunction

    function automatic logic [31:0] expRead(input int a);
        if (a < KW)          return keyMdl[a];
        if (a < KW + MW)     return msgMdl[a - KW];
        if (a < KW + 2 * MW) return resMdl[a - KW - MW];
        if (a == CTRL_A)     return {30'd0, ieMdl, 1'b0};
        if (a == STATUS_A)   return {28'd0, toMdl, lockMdl, doneMdl, busyMdl};
        return 32'd0;
    endfunction

    // One Avalon access; called and returning 1 time unit after a rising edge.
    task automatic applyStimulus(input bit isWrite, input int addr, input logic [31:0] data,
                                 input logic [3:0] be, output logic [31:0] rdata);
        AVL_CS        = 1'b1;
        AVL_ADDR      = AW'(addr);
        AVL_WRITE     = isWrite;
        AVL_READ      = !isWrite;
        AVL_WRITEDATA = data;
        AVL_BYTE_EN   = be;
        @(posedge CLK);
        #1;
        AVL_CS    = 1'b0;
        AVL_WRITE = 1'b0;
        AVL_READ  = 1'b0;
        rdata     = AVL_READDATA;
    endtask

    task automatic busWrite(input int addr, input logic [31:0] data, input logic [3:0] be);
        logic [31:0] dummy;
        if (addr < KW) begin
            if (busyMdl) lockMdl = 1;
            else         keyMdl[addr] = byteMerge(keyMdl[addr], data, be);
        end else if (addr < KW + MW) begin
            if (busyMdl) lockMdl = 1;
            else         msgMdl[addr - KW] = byteMerge(msgMdl[addr - KW], data, be);
        end else if (addr == CTRL_A && be[0]) begin
`ifdef CIPHER_CSR_IRQ_EN
            ieMdl = data[1];
`endif
        end else if (addr == STATUS_A && be[0]) begin
            if (data[1]) doneMdl = 0;
            if (data[2]) lockMdl = 0;
            if (data[3]) toMdl   = 0;
        end
        applyStimulus(1'b1, addr, data, be, dummy);
    endtask

    task automatic busRead(input int addr, input string tag, output logic [31:0] rd);
        applyStimulus(1'b0, addr, 32'd0, 4'h0, rd);
        checkOutput(tag, 128'(rd), 128'(expRead(addr)));
    endtask

    // Launches an operation; the core answers `delay` cycles after the launch edge.
    task automatic runOp(input int delay, input logic [127:0] result, input bit lockProbe);
        logic [31:0] dummy;
        int s0 = startCount;
        busyMdl = 1;
        applyStimulus(1'b1, CTRL_A, {30'd0, ieMdl, 1'b1}, 4'hF, dummy);
        doneMdl = 0;
        toMdl   = 0;
        checkOutput("core_start_hi", 128'(CORE_START), 128'(1));
        checkOutput("core_key", CORE_KEY, packWords(keyMdl));
        checkOutput("core_msg", CORE_MSG, packWords(msgMdl));
        if (lockProbe) begin
            busWrite(KW + 1, 32'h1234_5678, 4'hF);
            checkOutput("core_start_lo", 128'(CORE_START), 128'(0));
            busRead(STATUS_A, "status_busy_lock", dummy);
            checkOutput("status_busy_lock_const", 128'(dummy), 128'(32'h5));
            repeat (delay - 2) @(posedge CLK);
        end else begin
            repeat (delay) @(posedge CLK);
        end
        #1;
        CORE_DONE   = 1'b1;
        CORE_RESULT = result;
        @(posedge CLK);
        #1;
        CORE_DONE = 1'b0;
        busyMdl = 0;
        doneMdl = 1;
        for (int i = 0; i < MW; i++) resMdl[i] = result[127 - 32 * i -: 32];
        checkOutput("start_pulses", 128'(startCount - s0), 128'(1));
    endtask

    task automatic readResults(input string tag);
        logic [31:0] rd;
        for (int i = 0; i < MW; i++) busRead(KW + MW + i, tag, rd);
        busRead(STATUS_A, {tag, "_status"}, rd);
    endtask

    initial begin
        logic [31:0] rd;
        logic [127:0] r128;
        int s0;
        modelReset();

        // Reset state
        repeat (3) @(posedge CLK);
        #1;
        checkOutput("rst_rdata", 128'(AVL_READDATA), 128'(0));
        checkOutput("rst_core_start", 128'(CORE_START), 128'(0));
        checkOutput("rst_export", 128'(EXPORT_DATA), 128'(0));
        RESET = 1'b0;
        @(posedge CLK);
        #1;
        busRead(STATUS_A, "rst_status", rd);
        busRead(0, "rst_key0", rd);

        // Byte-enable merge into key word 0
        busWrite(0, 32'hFFFF_FFFF, 4'hF);
        busWrite(0, 32'h0001_0203, 4'b0101);
        busRead(0, "be_merge", rd);
        checkOutput("be_merge_const", 128'(rd), 128'(32'hFF01_FF03));
        checkOutput("export_hi", 128'(EXPORT_DATA[31:16]), 128'(16'hFF01));
        @(posedge CLK);
        #1;
        checkOutput("rdata_idle", 128'(AVL_READDATA), 128'(0));

        // Random register traffic, including RES and unmapped writes
        for (int n = 0; n < 40; n++) begin
            int a = $urandom_range(0, 13);
            if ($urandom_range(0, 1) == 1) busWrite(a, $urandom, 4'($urandom_range(0, 15)));
            else                           busRead(a, "rand_rd", rd);
        end
        for (int a = 0; a < 16; a++) busRead(a, "sweep_rd", rd);
        checkOutput("core_key_idle", CORE_KEY, packWords(keyMdl));
        checkOutput("core_msg_idle", CORE_MSG, packWords(msgMdl));
        checkOutput("export", 128'(EXPORT_DATA), 128'({keyMdl[0][31:16], keyMdl[KW-1][15:0]}));

        // CTRL bit1 is IE only when the interrupt is built in
        busWrite(CTRL_A, 32'hFFFF_FFFE, 4'hF);
        busRead(CTRL_A, "ctrl_rd", rd);
        busWrite(CTRL_A, 32'h0, 4'hF);

        // Reference operation with lock probe during BUSY
        runOp(10, 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D, 1'b1);
        readResults("op1_res");
        busRead(KW + 1, "msg_locked", rd);
        busWrite(STATUS_A, 32'h4, 4'hF);
        busRead(STATUS_A, "status_w1c", rd);
        checkOutput("status_w1c_const", 128'(rd), 128'(32'h2));

        // CORE_DONE outside BUSY must be ignored
        CORE_DONE = 1'b1;
        CORE_RESULT = {$urandom, $urandom, $urandom, $urandom};
        @(posedge CLK);
        #1;
        CORE_DONE = 1'b0;
        readResults("idle_done");

        // Random operations
        for (int n = 0; n < 4; n++) begin
            busWrite($urandom_range(0, KW - 1), $urandom, 4'hF);
            busWrite(KW + $urandom_range(0, MW - 1), $urandom, 4'($urandom_range(0, 15)));
            r128 = {$urandom, $urandom, $urandom, $urandom};
            runOp($urandom_range(1, TO - 1), r128, 1'b0);
            readResults("rand_op");
            busWrite(STATUS_A, 32'hE, 4'hF);
        end

        // Completion in the terminal-count cycle: done wins
        r128 = {$urandom, $urandom, $urandom, $urandom};
        runOp(TO, r128, 1'b0);
        readResults("edge_done");

        // Silent core: watchdog fires after TO BUSY cycles
        busWrite(STATUS_A, 32'hE, 4'hF);
        s0 = startCount;
        busyMdl = 1;
        applyStimulus(1'b1, CTRL_A, 32'h1, 4'hF, rd);
        doneMdl = 0;
        repeat (TO) @(posedge CLK);
        #1;
        busRead(STATUS_A, "to_last_busy", rd);
        busyMdl = 0;
        toMdl = 1;
        busRead(STATUS_A, "to_status", rd);
        checkOutput("to_status_const", 128'(rd), 128'(32'h8));
        checkOutput("to_start_pulses", 128'(startCount - s0), 128'(1));
        CORE_DONE = 1'b1;
        CORE_RESULT = {$urandom, $urandom, $urandom, $urandom};
        @(posedge CLK);
        #1;
        CORE_DONE = 1'b0;
        readResults("late_done");

        // Reset three cycles into BUSY
        busyMdl = 1;
        applyStimulus(1'b1, CTRL_A, 32'h1, 4'hF, rd);
        repeat (3) @(posedge CLK);
        #1;
        RESET = 1'b1;
        #1;
        modelReset();
        checkOutput("midrst_rdata", 128'(AVL_READDATA), 128'(0));
        checkOutput("midrst_start", 128'(CORE_START), 128'(0));
        checkOutput("midrst_key", CORE_KEY, 128'(0));
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        CORE_DONE = 1'b1;
        CORE_RESULT = {$urandom, $urandom, $urandom, $urandom};
        @(posedge CLK);
        #1;
        CORE_DONE = 1'b0;
        readResults("post_rst");

`ifdef CIPHER_CSR_IRQ_EN
        // Interrupt with IE set, cleared by W1C, and suppressed with IE clear
        busWrite(CTRL_A, 32'h2, 4'hF);
        checkOutput("irq_idle", 128'(AVL_IRQ), 128'(0));
        runOp(5, {$urandom, $urandom, $urandom, $urandom}, 1'b0);
        checkOutput("irq_set", 128'(AVL_IRQ), 128'(1));
        busWrite(STATUS_A, 32'h2, 4'hF);
        checkOutput("irq_clr", 128'(AVL_IRQ), 128'(0));
        busWrite(CTRL_A, 32'h0, 4'hF);
        runOp(5, {$urandom, $urandom, $urandom, $urandom}, 1'b0);
        checkOutput("irq_masked", 128'(AVL_IRQ), 128'(0));
        readResults("irq_op");
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL sim_timeout: got no finish, expected finish before 1ms");
        $fatal(1, "[TB] simulation time limit exceeded");
    end

endmodule
